pu_msp430_ram_dma: RTL and testbench

Single-port DMA engine that drives the low-active RAM port interface (addr/cen/wen/din/dout) used by the MSP430 data and program memories. It executes one block command at a time: a word copy with memmove semantics, so overlapping regions are handled, or a word fill. It sits on one RAM port as the access initiator, in bench and SoC memory subsystems, under control of a simple start/abort command interface.

---
 rtl/pu_msp430_ram_dma_pkg.sv | 21 ++
 rtl/pu_msp430_ram_dma_if.sv | 39 +++
 rtl/pu_msp430_ram_dma_addr_gen.sv | 47 ++++
 rtl/pu_msp430_ram_dma.sv | 157 +++++++++++++++
 tb/tb_pu_msp430_ram_dma.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pu_msp430_ram_dma_pkg.sv
// Shared types and constants for the MSP430 RAM DMA engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pu_msp430_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        FIN  = 3'd4
    } dma_state_e;

    localparam logic       MODE_COPY    = 1'b0;
    localparam logic       MODE_FILL    = 1'b1;

    // Low-active byte write enables: both high is a read, both low a word write.
    localparam logic [1:0] RAM_WEN_READ = 2'b11;
    localparam logic [1:0] RAM_WEN_WORD = 2'b00;

endpackage

// File: rtl/pu_msp430_ram_dma_if.sv
// Command/status and RAM port bundle between a DMA engine and its controller/RAM.
// Latency: none (wires only).
// Backpressure: none; the engine owns the RAM port while busy.
interface pu_msp430_ram_dma_if #(
    parameter int ADDR_MSB = 6
);
    logic                cfg_start;
    logic                cfg_mode;
    logic [ADDR_MSB:0]   cfg_src;
    logic [ADDR_MSB:0]   cfg_dst;
    logic [ADDR_MSB+1:0] cfg_len;
    logic [15:0]         cfg_fill;
    logic                cfg_abort;
    logic                busy;
    logic                done;
    logic                err;
    logic [ADDR_MSB:0]   ram_addr;
    logic                ram_cen;
    logic [1:0]          ram_wen;
    logic [15:0]         ram_din;
    logic [15:0]         ram_dout;

    // DMA engine side.
    modport slave (
        input  cfg_start, cfg_mode, cfg_src, cfg_dst, cfg_len, cfg_fill, cfg_abort,
        input  ram_dout,
        output busy, done, err,
        output ram_addr, ram_cen, ram_wen, ram_din
    );

    // Controller plus RAM side.
    modport master (
        output cfg_start, cfg_mode, cfg_src, cfg_dst, cfg_len, cfg_fill, cfg_abort,
        output ram_dout,
        input  busy, done, err,
        input  ram_addr, ram_cen, ram_wen, ram_din
    );

endinterface

// File: rtl/pu_msp430_ram_dma_addr_gen.sv
// Loadable up/down word address counter; direction is captured at load time.
// Latency: addr_nxt_o is the value the register takes at the next edge (0 cycles).
// Backpressure: none; steps only when step_i is high.
module pu_msp430_dma_addr_gen #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          down_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_nxt_o
);
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic          down_q;
    logic          down_d;

    // Next address: load wins over step; step follows the captured direction.
    always_comb begin
        addr_d = addr_q;
        down_d = down_q;
        if (load_i) begin
            addr_d = load_val_i;
            down_d = down_i;
        end else if (step_i) begin
            addr_d = down_q ? (addr_q - AW'(1)) : (addr_q + AW'(1));
        end
    end

    // Counter and direction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end

    // The owner registers the RAM address from the next value so the
    // registered address lines up with the state being entered.
    assign addr_nxt_o = addr_d;

endmodule

// File: rtl/pu_msp430_ram_dma.sv
// Block copy (memmove) / fill DMA driving a low-active single-port MSP430 RAM.
// Latency: first access 1 cycle after start; copy 2 cycles/word, fill 1 cycle/word, done one cycle later.
// Backpressure: none; start is ignored while busy, abort ends the command after the current access.
module pu_msp430_ram_dma
    import pu_msp430_dma_pkg::*;
#(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic                 mclk,
    input  logic                 puc_rst,
    pu_msp430_ram_dma_if.slave   bus
);
    localparam int AW = ADDR_MSB + 1;
    localparam int LW = ADDR_MSB + 2;
    // One extra carry bit so start+len can never wrap before the range compare.
    localparam int SW = ADDR_MSB + 3;
    localparam logic [SW-1:0] WORDS = SW'(MEM_SIZE / 2);

    dma_state_e    state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ram_cen_q, ram_cen_d;
    logic [1:0]    ram_wen_q, ram_wen_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]   ram_din_q, ram_din_d;

    logic [SW-1:0] src_end, dst_end;
    logic          range_err, copy_down, load, step;
    logic [AW-1:0] src_load, dst_load, src_nxt, dst_nxt;

    // Command decode: end-exclusive bounds, direction and first addresses.
    assign src_end   = SW'(bus.cfg_src) + SW'(bus.cfg_len);
    assign dst_end   = SW'(bus.cfg_dst) + SW'(bus.cfg_len);
    assign range_err = ((bus.cfg_mode == MODE_COPY) && (src_end > WORDS)) || (dst_end > WORDS);
    assign copy_down = (bus.cfg_mode == MODE_COPY) && (bus.cfg_dst > bus.cfg_src);
    assign src_load  = copy_down ? AW'(src_end - SW'(1)) : bus.cfg_src;
    assign dst_load  = copy_down ? AW'(dst_end - SW'(1)) : bus.cfg_dst;

    pu_msp430_dma_addr_gen #(.AW(AW)) u_src_gen (
        .clk        (mclk),
        .rst        (puc_rst),
        .load_i     (load),
        .load_val_i (src_load),
        .down_i     (copy_down),
        .step_i     (step),
        .addr_nxt_o (src_nxt)
    );

    pu_msp430_dma_addr_gen #(.AW(AW)) u_dst_gen (
        .clk        (mclk),
        .rst        (puc_rst),
        .load_i     (load),
        .load_val_i (dst_load),
        .down_i     (copy_down),
        .step_i     (step),
        .addr_nxt_o (dst_nxt)
    );

    // Next state, word count and address stepping. The last word never steps,
    // so the address counters stay inside the block at both ends of memory.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    load  = 1'b1;
                    cnt_d = bus.cfg_len;
                    if (range_err) begin
                        state_d = FIN;
                        err_d   = 1'b1;
                    end else if (bus.cfg_len == '0) begin
                        state_d = FIN;
                    end else if (bus.cfg_mode == MODE_COPY) begin
                        state_d = RD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            RD: begin
                state_d = bus.cfg_abort ? FIN : WR;
            end
            WR, FILL: begin
                cnt_d = cnt_q - LW'(1);
                if (bus.cfg_abort || (cnt_q == LW'(1))) begin
                    state_d = FIN;
                end else begin
                    state_d = (state_q == WR) ? RD : FILL;
                    step    = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the state being entered so they
    // line up with that state's cycle.
    always_comb begin
        busy_d     = (state_d == RD) || (state_d == WR) || (state_d == FILL);
        done_d     = (state_d == FIN);
        ram_cen_d  = !busy_d;
        ram_wen_d  = ((state_d == WR) || (state_d == FILL)) ? RAM_WEN_WORD : RAM_WEN_READ;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (state_d == RD) begin
            ram_addr_d = src_nxt;
        end else if ((state_d == WR) || (state_d == FILL)) begin
            ram_addr_d = dst_nxt;
        end
        if ((state_q == IDLE) && (state_d == FILL)) begin
            ram_din_d = bus.cfg_fill;
        end
    end

    // State, count and output registers.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ram_cen_q  <= 1'b1;
            ram_wen_q  <= RAM_WEN_READ;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ram_cen_q  <= ram_cen_d;
            ram_wen_q  <= ram_wen_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ram_cen  = ram_cen_q;
    assign bus.ram_wen  = ram_wen_q;
    assign bus.ram_addr = ram_addr_q;
    // Copy writes forward the word read in the preceding RD cycle straight through.
    assign bus.ram_din  = (state_q == WR) ? bus.ram_dout : ram_din_q;

endmodule

// File: tb/tb_pu_msp430_ram_dma.sv
// Bench for the MSP430 RAM DMA: directed commands against a behavioural RAM.
// Latency: expected done latency and write order are queued per command.
// Backpressure: none; a negedge monitor drains the expected queues.
module tb_pu_msp430_ram_dma;

    typedef struct {
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int   lat;
        logic err;
    } done_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem [0:127];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int acc_cnt   = 0;
    int acc_base  = 0;
    int done_cnt  = 0;
    logic [6:0] first_addr = '0;

    wr_t   exp_wr[$];
    done_t exp_done[$];

    pu_msp430_ram_dma_if #(.ADDR_MSB(6)) bus ();

    pu_msp430_ram_dma #(.ADDR_MSB(6), .MEM_SIZE(256)) dut (
        .mclk    (clk),
        .puc_rst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM: read data appears after the enabled edge.
    always @(posedge clk) begin
        if (!bus.ram_cen) begin
            if (bus.ram_wen == 2'b00) mem[bus.ram_addr] <= bus.ram_din;
            else                      bus.ram_dout      <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals done.
    always @(negedge clk) begin
        wr_t   w;
        done_t e;
        if (!rst) begin
            if (!bus.ram_cen) begin
                if (acc_cnt == acc_base) first_addr = bus.ram_addr;
                acc_cnt++;
                if (bus.ram_wen == 2'b00) begin
                    check("wr_pending", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) begin
                        w = exp_wr.pop_front();
                        check("wr_addr", bus.ram_addr, w.a);
                        check("wr_data", bus.ram_din, w.d);
                    end
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("done_pending", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    e = exp_done.pop_front();
                    check("done_latency", cyc - start_cyc, e.lat);
                    check("done_err", bus.err, e.err);
                end
                check("busy_at_done", bus.busy, 0);
            end else if (bus.err) begin
                check("err_without_done", bus.err, 0);
            end
        end
    end

    task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_done(input int lat, input logic err);
        done_t e;
        e.lat = lat;
        e.err = err;
        exp_done.push_back(e);
    endtask

    // Issue a one-cycle start; returns one cycle later (cycle 1 of the command).
    task automatic start_cmd(input logic mode, input logic [6:0] src, input logic [6:0] dst,
                             input logic [7:0] len, input logic [15:0] fill);
        bus.cfg_mode  = mode;
        bus.cfg_src   = src;
        bus.cfg_dst   = dst;
        bus.cfg_len   = len;
        bus.cfg_fill  = fill;
        bus.cfg_start = 1'b1;
        start_cyc     = cyc;
        acc_base      = acc_cnt;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
        check("done_timeout", done_cnt >= target, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_mode  = 1'b0;
        bus.cfg_src   = '0;
        bus.cfg_dst   = '0;
        bus.cfg_len   = '0;
        bus.cfg_fill  = '0;
        bus.cfg_abort = 1'b0;
        bus.ram_dout  = '0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);

        repeat (3) @(posedge clk); #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_cen", bus.ram_cen, 1);
        check("rst_wen", bus.ram_wen, 2'b11);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_din", bus.ram_din, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Copy 0x10 -> 0x20, 4 words; dst > src so it runs descending.
        push_wr(7'h23, 16'h1013); push_wr(7'h22, 16'h1012);
        push_wr(7'h21, 16'h1011); push_wr(7'h20, 16'h1010);
        push_done(9, 1'b0);
        start_cmd(1'b0, 7'h10, 7'h20, 8'd4, 16'h0);
        wait_done(40);
        for (int i = 0; i < 4; i++) check("t1_mem", mem[7'h20 + 7'(i)], 16'h1010 + 16'(i));
        check("t1_accesses", acc_cnt - acc_base, 8);
        check("t1_first_addr", first_addr, 7'h13);

        // Overlapping copy 0x10 -> 0x12 holding A,B,C,D.
        mem[7'h10] = 16'hAAAA; mem[7'h11] = 16'hBBBB;
        mem[7'h12] = 16'hCCCC; mem[7'h13] = 16'hDDDD;
        push_wr(7'h15, 16'hDDDD); push_wr(7'h14, 16'hCCCC);
        push_wr(7'h13, 16'hBBBB); push_wr(7'h12, 16'hAAAA);
        push_done(9, 1'b0);
        start_cmd(1'b0, 7'h10, 7'h12, 8'd4, 16'h0);
        wait_done(40);
        check("t2_mem12", mem[7'h12], 16'hAAAA);
        check("t2_mem13", mem[7'h13], 16'hBBBB);
        check("t2_mem14", mem[7'h14], 16'hCCCC);
        check("t2_mem15", mem[7'h15], 16'hDDDD);
        check("t2_first_addr", first_addr, 7'h13);

        // Fill up to the last word of memory.
        for (int i = 0; i < 4; i++) push_wr(7'h7C + 7'(i), 16'hBEEF);
        push_done(5, 1'b0);
        start_cmd(1'b1, 7'h0, 7'h7C, 8'd4, 16'hBEEF);
        wait_done(40);
        for (int i = 0; i < 4; i++) check("t3_mem", mem[7'h7C + 7'(i)], 16'hBEEF);

        // One past the end: error, no access.
        push_done(1, 1'b1);
        start_cmd(1'b1, 7'h0, 7'h7D, 8'd4, 16'h5555);
        wait_done(40);
        check("t3b_accesses", acc_cnt - acc_base, 0);

        // Zero length copy.
        push_done(1, 1'b0);
        start_cmd(1'b0, 7'h05, 7'h06, 8'd0, 16'h0);
        wait_done(40);
        check("t4_accesses", acc_cnt - acc_base, 0);

        // Start pulsed while busy is ignored.
        push_wr(7'h40, 16'h1234); push_wr(7'h41, 16'h1234); push_wr(7'h42, 16'h1234);
        push_done(4, 1'b0);
        start_cmd(1'b1, 7'h0, 7'h40, 8'd3, 16'h1234);
        bus.cfg_mode  = 1'b0;
        bus.cfg_src   = 7'h00;
        bus.cfg_dst   = 7'h50;
        bus.cfg_len   = 8'd2;
        bus.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        wait_done(40);
        check("t5_mem50", mem[7'h50], 16'h1050);
        check("t5_accesses", acc_cnt - acc_base, 3);

        // Abort in the WR of word 2 of an ascending 6-word copy.
        push_wr(7'h00, 16'h1030); push_wr(7'h01, 16'h1031); push_wr(7'h02, 16'h1032);
        push_done(7, 1'b0);
        start_cmd(1'b0, 7'h30, 7'h00, 8'd6, 16'h0);
        repeat (5) @(posedge clk); #1;
        bus.cfg_abort = 1'b1;
        @(posedge clk); #1;
        bus.cfg_abort = 1'b0;
        wait_done(40);
        for (int i = 0; i < 3; i++) check("t6_written", mem[7'(i)], 16'h1030 + 16'(i));
        for (int i = 3; i < 6; i++) check("t6_untouched", mem[7'(i)], 16'h1000 + 16'(i));

        // Reset in the middle of a fill.
        push_wr(7'h60, 16'h5A5A); push_wr(7'h61, 16'h5A5A);
        start_cmd(1'b1, 7'h0, 7'h60, 8'd8, 16'h5A5A);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t7_cen", bus.ram_cen, 1);
        check("t7_busy", bus.busy, 0);
        check("t7_wen", bus.ram_wen, 2'b11);
        check("t7_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t7_mem61", mem[7'h61], 16'h5A5A);
        check("t7_mem62", mem[7'h62], 16'h1062);

        // New command after reset: descending copy 0x61 -> 0x70.
        push_wr(7'h71, 16'h1062); push_wr(7'h70, 16'h5A5A);
        push_done(5, 1'b0);
        start_cmd(1'b0, 7'h61, 7'h70, 8'd2, 16'h0);
        wait_done(40);
        check("t8_mem70", mem[7'h70], 16'h5A5A);
        check("t8_mem71", mem[7'h71], 16'h1062);

        check("wr_queue_empty", exp_wr.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        check("done_count", done_cnt, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
